// File: rtl/axi_lite_data_ram_if.sv
// AXI4-Lite bundle between the LSU (master) and the data RAM (slave).
// The clock and reset are kept outside the bundle as plain ports.
interface axi_lite_data_ram_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [31:0] awaddr;
  logic        awvalid;
  logic        awready;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wvalid;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/axi_lite_data_ram.sv
// AXI4-Lite slave word RAM for LSU loads and stores.
// The read and write channels run independent FSMs, each with one transaction in flight.
module axi_lite_data_ram #(
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH_WORDS = 4096,
  parameter int unsigned READ_LAT    = 1
) (
  input logic                i_clk,
  input logic                i_rst_n,
  axi_lite_data_ram_if.slave bus
);

  localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
  localparam logic [32:0] RANGE_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [3:0]  LAT         = 4'(READ_LAT);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE, R_WAIT, R_RESP} rState_t;
  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wState_t;

  logic [31:0] r_mem [DEPTH_WORDS];

  // The offset is widened to 33 bits so the range test cannot wrap near the top of the map.
  logic [31:0]      w_arOff;
  logic [31:0]      w_awOff;
  logic             w_arInRange;
  logic             w_awInRange;
  logic [IDX_W-1:0] w_arIdx;
  logic [IDX_W-1:0] w_awIdx;

  assign w_arOff     = bus.araddr - BASE_ADDR;
  assign w_awOff     = bus.awaddr - BASE_ADDR;
  assign w_arInRange = (bus.araddr >= BASE_ADDR) && ({1'b0, w_arOff} < RANGE_BYTES);
  assign w_awInRange = (bus.awaddr >= BASE_ADDR) && ({1'b0, w_awOff} < RANGE_BYTES);
  assign w_arIdx     = w_arOff[IDX_W+1:2];
  assign w_awIdx     = w_awOff[IDX_W+1:2];

  rState_t     r_rState;
  logic [3:0]  r_rCnt;
  logic [31:0] r_rWord;
  logic        r_rErr;
  logic        r_arready;
  logic        r_rvalid;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;
  logic        w_arHs;
  logic        w_rHs;

  assign w_arHs = bus.arvalid & r_arready;
  assign w_rHs  = r_rvalid & bus.rready;

  // The word is sampled at the AR handshake but only exposed on rdata when rvalid rises.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rState  <= R_IDLE;
      r_rCnt    <= 4'd0;
      r_rWord   <= 32'h0;
      r_rErr    <= 1'b0;
      r_arready <= 1'b1;
      r_rvalid  <= 1'b0;
      r_rdata   <= 32'h0;
      r_rresp   <= RESP_OKAY;
    end else begin
      unique case (r_rState)
        R_IDLE: begin
          if (w_arHs) begin
            r_arready <= 1'b0;
            if (LAT == 4'd0) begin
              r_rdata  <= w_arInRange ? r_mem[w_arIdx] : 32'h0;
              r_rresp  <= w_arInRange ? RESP_OKAY : RESP_SLVERR;
              r_rvalid <= 1'b1;
              r_rState <= R_RESP;
            end else begin
              r_rWord  <= r_mem[w_arIdx];
              r_rErr   <= !w_arInRange;
              r_rCnt   <= LAT;
              r_rState <= R_WAIT;
            end
          end
        end
        R_WAIT: begin
          if (r_rCnt <= 4'd1) begin
            r_rdata  <= r_rErr ? 32'h0 : r_rWord;
            r_rresp  <= r_rErr ? RESP_SLVERR : RESP_OKAY;
            r_rvalid <= 1'b1;
            r_rState <= R_RESP;
          end else begin
            r_rCnt <= r_rCnt - 4'd1;
          end
        end
        R_RESP: begin
          if (w_rHs) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
            r_rState  <= R_IDLE;
          end
        end
        default: r_rState <= R_IDLE;
      endcase
    end
  end

  wState_t          r_wState;
  logic             r_awready;
  logic             r_wready;
  logic             r_bvalid;
  logic [1:0]       r_bresp;
  logic [IDX_W-1:0] r_awIdx;
  logic             r_awInRange;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;
  logic             w_awHs;
  logic             w_wHs;
  logic             w_bHs;
  logic             w_commit;
  logic [IDX_W-1:0] w_cIdx;
  logic             w_cInRange;
  logic [31:0]      w_cData;
  logic [3:0]       w_cStrb;

  assign w_awHs = bus.awvalid & r_awready;
  assign w_wHs  = bus.wvalid & r_wready;
  assign w_bHs  = r_bvalid & bus.bready;

  // Commit happens on the edge where the second of AW/W arrives, mixing held and live halves.
  always_comb begin
    w_commit = 1'b0;
    unique case (r_wState)
      W_IDLE:  w_commit = w_awHs & w_wHs;
      W_ADDR:  w_commit = w_wHs;
      W_DATA:  w_commit = w_awHs;
      default: w_commit = 1'b0;
    endcase
  end

  assign w_cIdx     = (r_wState == W_ADDR) ? r_awIdx     : w_awIdx;
  assign w_cInRange = (r_wState == W_ADDR) ? r_awInRange : w_awInRange;
  assign w_cData    = (r_wState == W_DATA) ? r_wdata     : bus.wdata;
  assign w_cStrb    = (r_wState == W_DATA) ? r_wstrb     : bus.wstrb;

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge i_clk) begin
    if (w_commit && w_cInRange) begin
      for (int b = 0; b < 4; b++) begin
        if (w_cStrb[b]) begin
          r_mem[w_cIdx][8*b +: 8] <= w_cData[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wState    <= W_IDLE;
      r_awready   <= 1'b1;
      r_wready    <= 1'b1;
      r_bvalid    <= 1'b0;
      r_bresp     <= RESP_OKAY;
      r_awIdx     <= '0;
      r_awInRange <= 1'b0;
      r_wdata     <= 32'h0;
      r_wstrb     <= 4'h0;
    end else begin
      unique case (r_wState)
        W_IDLE: begin
          if (w_commit) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_cInRange ? RESP_OKAY : RESP_SLVERR;
            r_wState  <= W_RESP;
          end else if (w_awHs) begin
            r_awready   <= 1'b0;
            r_awIdx     <= w_awIdx;
            r_awInRange <= w_awInRange;
            r_wState    <= W_ADDR;
          end else if (w_wHs) begin
            r_wready <= 1'b0;
            r_wdata  <= bus.wdata;
            r_wstrb  <= bus.wstrb;
            r_wState <= W_DATA;
          end
        end
        W_ADDR, W_DATA: begin
          if (w_commit) begin
            r_awready <= 1'b0;
            r_wready  <= 1'b0;
            r_bvalid  <= 1'b1;
            r_bresp   <= w_cInRange ? RESP_OKAY : RESP_SLVERR;
            r_wState  <= W_RESP;
          end
        end
        W_RESP: begin
          if (w_bHs) begin
            r_bvalid  <= 1'b0;
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_wState  <= W_IDLE;
          end
        end
        default: r_wState <= W_IDLE;
      endcase
    end
  end

  assign bus.arready = r_arready;
  assign bus.rvalid  = r_rvalid;
  assign bus.rdata   = r_rdata;
  assign bus.rresp   = r_rresp;
  assign bus.awready = r_awready;
  assign bus.wready  = r_wready;
  assign bus.bvalid  = r_bvalid;
  assign bus.bresp   = r_bresp;

endmodule

// File: tb/tb_axi_lite_data_ram.sv
// Self-checking bench for axi_lite_data_ram: directed scenarios followed by random
// traffic, all compared against a word-array model of the memory map.
module tb_axi_lite_data_ram;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam int          DEPTH = 4096;
  localparam int          LAT   = 1;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  int   checkCount = 0;
  int   errorCount = 0;

  logic [31:0] modelMem [int];
  logic [31:0] pool [8];

  axi_lite_data_ram_if bus ();

  axi_lite_data_ram #(
    .BASE_ADDR  (BASE),
    .DEPTH_WORDS(DEPTH),
    .READ_LAT   (LAT)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rstN),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic bit inRange(input logic [31:0] a);
    longint la = longint'(a);
    longint lb = longint'(BASE);
    return (la >= lb) && (la < lb + 4 * DEPTH);
  endfunction

  function automatic int wordIdx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  function automatic logic [31:0] mergeBytes(input logic [31:0] oldW, input logic [31:0] newW,
                                             input logic [3:0] strb);
    logic [31:0] res = oldW;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) res[8*i +: 8] = newW[8*i +: 8];
    end
    return res;
  endfunction

  // Drives one write with independent AW/W start delays and B backpressure.
  task automatic applyWriteStimulus(input logic [31:0] addr, input logic [31:0] data,
                                    input logic [3:0] strb, input int awDelay, input int wDelay,
                                    input int bDelay, input string tag);
    bit awDone = 0;
    bit wDone = 0;
    bit awHs;
    bit wHs;
    int cyc = 0;
    logic [1:0] expResp = inRange(addr) ? 2'b00 : 2'b10;
    @(negedge clk);
    bus.awaddr = addr;
    bus.wdata  = data;
    bus.wstrb  = strb;
    while (!(awDone && wDone) && cyc < 50) begin
      bus.awvalid = !awDone && (cyc >= awDelay);
      bus.wvalid  = !wDone && (cyc >= wDelay);
      awHs = bus.awvalid && bus.awready;
      wHs  = bus.wvalid && bus.wready;
      @(negedge clk);
      cyc++;
      if (awHs) awDone = 1;
      if (wHs) wDone = 1;
      if (awDone != wDone) begin
        checkOutput($sformatf("%s bvalid early", tag), 32'(bus.bvalid), 32'd0);
        if (awDone) checkOutput($sformatf("%s awready held low", tag), 32'(bus.awready), 32'd0);
        else        checkOutput($sformatf("%s wready held low", tag), 32'(bus.wready), 32'd0);
      end
    end
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    if (!(awDone && wDone)) begin
      checkOutput($sformatf("%s AW/W accept timeout", tag), 32'd0, 32'd1);
      return;
    end
    if (inRange(addr)) begin
      int idx = wordIdx(addr);
      logic [31:0] oldW = modelMem.exists(idx) ? modelMem[idx] : 32'h0;
      modelMem[idx] = mergeBytes(oldW, data, strb);
    end
    checkOutput($sformatf("%s bvalid", tag), 32'(bus.bvalid), 32'd1);
    checkOutput($sformatf("%s bresp", tag), 32'(bus.bresp), 32'(expResp));
    for (int i = 0; i < bDelay; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s bvalid stall", tag), 32'(bus.bvalid), 32'd1);
      checkOutput($sformatf("%s bresp stall", tag), 32'(bus.bresp), 32'(expResp));
      checkOutput($sformatf("%s aw/w ready stall", tag), 32'({bus.awready, bus.wready}), 32'd0);
    end
    bus.bready = 1'b1;
    @(negedge clk);
    bus.bready = 1'b0;
    checkOutput($sformatf("%s bvalid drop", tag), 32'(bus.bvalid), 32'd0);
    checkOutput($sformatf("%s aw/w ready back", tag), 32'({bus.awready, bus.wready}), 32'd3);
    @(negedge clk);
    checkOutput($sformatf("%s single bvalid pulse", tag), 32'(bus.bvalid), 32'd0);
  endtask

  // Drives one read, checks latency, data, response and stability under rready backpressure.
  task automatic applyReadStimulus(input logic [31:0] addr, input int rDelay, input string tag);
    logic [31:0] expData = 32'h0;
    logic [1:0]  expResp = 2'b10;
    bit          checkData = 1;
    int          waitCyc = 0;
    logic [31:0] held;
    if (inRange(addr)) begin
      expResp = 2'b00;
      if (modelMem.exists(wordIdx(addr))) expData = modelMem[wordIdx(addr)];
      else checkData = 0;
    end
    @(negedge clk);
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    while (!bus.arready && waitCyc < 50) begin
      @(negedge clk);
      waitCyc++;
    end
    if (!bus.arready) begin
      bus.arvalid = 1'b0;
      checkOutput($sformatf("%s AR accept timeout", tag), 32'd0, 32'd1);
      return;
    end
    @(negedge clk);
    bus.arvalid = 1'b0;
    waitCyc = 1;
    while (!bus.rvalid && waitCyc < 50) begin
      checkOutput($sformatf("%s arready low pending", tag), 32'(bus.arready), 32'd0);
      @(negedge clk);
      waitCyc++;
    end
    checkOutput($sformatf("%s rvalid latency", tag), 32'(waitCyc), 32'(LAT + 1));
    if (!bus.rvalid) return;
    checkOutput($sformatf("%s rresp", tag), 32'(bus.rresp), 32'(expResp));
    if (checkData) checkOutput($sformatf("%s rdata", tag), bus.rdata, expData);
    held = bus.rdata;
    for (int i = 0; i < rDelay; i++) begin
      @(negedge clk);
      checkOutput($sformatf("%s rvalid stall", tag), 32'(bus.rvalid), 32'd1);
      checkOutput($sformatf("%s rdata stall", tag), bus.rdata, held);
      checkOutput($sformatf("%s arready stall", tag), 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    @(negedge clk);
    bus.rready = 1'b0;
    checkOutput($sformatf("%s rvalid drop", tag), 32'(bus.rvalid), 32'd0);
    checkOutput($sformatf("%s arready back", tag), 32'(bus.arready), 32'd1);
    checkOutput($sformatf("%s rdata hold", tag), bus.rdata, held);
  endtask

  initial begin
    int waitCyc;
    bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0;
    bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    #12;
    checkOutput("reset arready", 32'(bus.arready), 32'd1);
    checkOutput("reset awready", 32'(bus.awready), 32'd1);
    checkOutput("reset wready", 32'(bus.wready), 32'd1);
    checkOutput("reset rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("reset bvalid", 32'(bus.bvalid), 32'd0);
    checkOutput("reset rdata", bus.rdata, 32'd0);
    checkOutput("reset rresp", 32'(bus.rresp), 32'd0);
    checkOutput("reset bresp", 32'(bus.bresp), 32'd0);
    @(negedge clk);
    rstN = 1'b1;

    $display("[TB] basic write/read");
    applyWriteStimulus(32'h8000_0010, 32'hDEAD_BEEF, 4'b1111, 0, 0, 0, "wr full");
    applyReadStimulus(32'h8000_0010, 0, "rd full");
    applyWriteStimulus(32'h8000_0010, 32'h0000_5500, 4'b0010, 0, 0, 0, "wr strb0010");
    applyReadStimulus(32'h8000_0012, 0, "rd partial");
    checkOutput("partial word literal", bus.rdata, 32'hDEAD_55EF);
    applyWriteStimulus(32'h8000_0010, 32'hFFFF_FFFF, 4'b0000, 0, 0, 0, "wr strb0000");
    applyReadStimulus(32'h8000_0010, 0, "rd nostrb");

    $display("[TB] W before AW, backpressure");
    applyWriteStimulus(32'h8000_0020, 32'h1234_5678, 4'b1111, 3, 0, 5, "wr w-first");
    applyWriteStimulus(32'h8000_0024, 32'h0BAD_F00D, 4'b1111, 0, 2, 0, "wr aw-first");
    applyReadStimulus(32'h8000_0020, 5, "rd stall");
    applyReadStimulus(32'h8000_0024, 0, "rd aw-first");

    $display("[TB] range boundaries");
    applyWriteStimulus(BASE, 32'hA5A5_5A5A, 4'b1111, 0, 0, 0, "wr word0");
    applyReadStimulus(32'h7FFF_FFFC, 0, "rd below base");
    applyWriteStimulus(BASE + 32'(4 * DEPTH), 32'hFFFF_FFFF, 4'b1111, 1, 0, 2, "wr past end");
    applyReadStimulus(BASE, 0, "rd word0 untouched");
    applyWriteStimulus(BASE + 32'(4 * DEPTH - 4), 32'hC0DE_0001, 4'b1111, 0, 0, 0, "wr last");
    applyReadStimulus(BASE + 32'(4 * DEPTH - 4), 1, "rd last");
    applyReadStimulus(BASE + 32'(4 * DEPTH), 0, "rd past end");

    $display("[TB] reset during pending read");
    @(negedge clk);
    bus.araddr  = 32'h8000_0020;
    bus.arvalid = 1'b1;
    @(negedge clk);
    bus.arvalid = 1'b0;
    waitCyc = 0;
    while (!bus.rvalid && waitCyc < 20) begin
      @(negedge clk);
      waitCyc++;
    end
    checkOutput("rst rvalid before", 32'(bus.rvalid), 32'd1);
    #2;
    rstN = 1'b0;
    #1;
    checkOutput("rst async rvalid", 32'(bus.rvalid), 32'd0);
    checkOutput("rst async arready", 32'(bus.arready), 32'd1);
    checkOutput("rst async rdata", bus.rdata, 32'd0);
    @(negedge clk);
    rstN = 1'b1;
    applyReadStimulus(32'h8000_0020, 0, "rd after reset");
    applyReadStimulus(32'h8000_0010, 0, "rd after reset 2");

    $display("[TB] concurrent channels");
    pool = '{32'h8000_0000, 32'h8000_0004, 32'h8000_0010, 32'h8000_0100,
             32'h8000_1000, 32'h8000_2AB0, 32'h8000_3000, 32'h8000_3FFC};
    foreach (pool[i]) applyWriteStimulus(pool[i], $urandom, 4'b1111, 0, 0, 0, "wr seed");
    fork
      applyWriteStimulus(pool[1], 32'h5555_AAAA, 4'b1111, 1, 2, 1, "wr conc");
      applyReadStimulus(pool[2], 2, "rd conc");
    join
    applyReadStimulus(pool[1], 0, "rd after conc");

    $display("[TB] random traffic");
    for (int n = 0; n < 60; n++) begin
      logic [31:0] addr;
      int op = $urandom_range(0, 9);
      if (op == 9) begin
        case ($urandom_range(0, 3))
          0: addr = BASE - 32'd4;
          1: addr = BASE + 32'(4 * DEPTH);
          2: addr = 32'h0000_0000;
          default: addr = 32'hFFFF_FFFC;
        endcase
      end else begin
        addr = pool[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      end
      if (op < 5) begin
        applyWriteStimulus(addr, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 3),
                           $urandom_range(0, 3), $urandom_range(0, 3), $sformatf("rnd wr %0d", n));
      end else if (op < 9) begin
        applyReadStimulus(addr, $urandom_range(0, 3), $sformatf("rnd rd %0d", n));
      end else if ($urandom_range(0, 1) == 1) begin
        applyWriteStimulus(addr, $urandom, 4'b1111, 0, 0, 0, $sformatf("rnd oor wr %0d", n));
      end else begin
        applyReadStimulus(addr, 0, $sformatf("rnd oor rd %0d", n));
      end
    end
    foreach (pool[i]) applyReadStimulus(pool[i], 0, "final sweep");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
